// File: rtl/posit_pack_seq.sv
// posit_pack_seq
// Serial posit encoder. It packs a decoded operand into a WORD_SIZE-bit posit:
//   - sign
//   - combined regime/exponent scale
//   - MSB-aligned fraction without the hidden bit
// The regime run is shifted into a 2N-bit working register one bit per clock.
// The result is rounded to nearest, ties to even. It never rounds to zero or
// to NaR.
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous reset, active high
//   start    accept request (sampled only when idle)
//   sign     result sign
//   scale    signed scale; k = scale >>> ES, e = scale[ES-1:0]
//   frac     fraction after the hidden 1, MSB-aligned
//   zero_in  force zero result
//   inf_in   force NaR result (wins over zero_in)
//   busy     high from the capture edge until the result is valid
//   out      packed posit, held until the next result
//   valid    one-cycle pulse when out is updated
//   inf      NaR flag, registered with out
//   zero     zero flag, registered with out
module posit_pack_seq #(
   parameter int WORD_SIZE = 32,
   parameter int RS        = 5,
   parameter int ES        = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    sign,
   input  logic [RS+ES:0]          scale,
   input  logic [WORD_SIZE-ES-1:0] frac,
   input  logic                    zero_in,
   input  logic                    inf_in,
   output logic                    busy,
   output logic [WORD_SIZE-1:0]    out,
   output logic                    valid,
   output logic                    inf,
   output logic                    zero
);

   // state | meaning
   // IDLE  | waiting for start; captures the operand when start is seen
   // SHIFT | shifts one regime run bit into T per clock until the count expires
   // ROUND | rounds the body, applies sign/specials, registers the result

   localparam int N  = WORD_SIZE;
   localparam int SW = RS + ES + 1;

   localparam logic signed [SW-1:0] K_MAX  = SW'(N - 2);
   localparam logic signed [SW-1:0] K_MIN  = SW'(1 - N);
   localparam logic signed [SW-1:0] K_ONE  = SW'(1);
   localparam logic [RS-1:0]        ONE_RS = {{(RS-1){1'b0}}, 1'b1};
   localparam logic [N-1:0]         ONE_N  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-2:0]         ONE_B  = {{(N-2){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, SHIFT, ROUND} state_t;

   state_t state, state_nxt;

   logic [2*N-1:0] t_reg;
   logic           sticky;
   logic           run_bit;
   logic           sign_r;
   logic [RS-1:0]  cnt;
   logic           sp_inf, sp_zero, sp_max, sp_min;

   // operand decode at capture time
   logic signed [SW-1:0] scale_s, k_val;
   logic                 k_neg;
   logic [RS-1:0]        run_in;
   logic [N:0]           tail;
   logic                 k_over, k_under;
   logic                 in_special;

   assign scale_s = scale;
   assign k_val   = scale_s >>> ES;
   assign k_neg   = k_val[SW-1];
   // positive regimes emit k+1 ones, negative ones emit -k zeros
   assign run_in  = k_neg ? RS'(-k_val) : RS'(k_val + K_ONE);
   assign k_over  = (k_val >= K_MAX);
   assign k_under = (k_val <= K_MIN);
   assign in_special = inf_in | zero_in | k_over | k_under;

   // terminating regime bit is the complement of the run bit
   if (ES > 0) begin : g_exp
      assign tail = {k_neg, scale[ES-1:0], frac};
   end else begin : g_noexp
      assign tail = {k_neg, frac};
   end

   // rounding of the shifted register
   logic [N-2:0] body, body_rnd;
   logic         guard, sticky_all, round_up;
   logic [N-1:0] mag, res;

   assign body       = t_reg[2*N-1:N+1];
   assign guard      = t_reg[N];
   assign sticky_all = sticky | (|t_reg[N-1:0]);
   // an all-ones body would carry into the sign bit; hold it at maxpos instead
   assign round_up   = guard & (sticky_all | body[0]) & ~(&body);

   always_comb begin
      body_rnd = body + (round_up ? ONE_B : '0);
      if (body_rnd == '0) begin
         body_rnd = ONE_B;
      end
      mag = {1'b0, body_rnd};
      if (sp_max) begin
         mag = {1'b0, {(N-1){1'b1}}};
      end else if (sp_min) begin
         mag = ONE_N;
      end
      res = sign_r ? (~mag + ONE_N) : mag;
      if (sp_inf) begin
         res = {1'b1, {(N-1){1'b0}}};
      end else if (sp_zero) begin
         res = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (in_special || run_in == '0) ? ROUND : SHIFT;
            end
         end
         SHIFT: begin
            if (cnt <= ONE_RS) begin
               state_nxt = ROUND;
            end
         end
         ROUND:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t_reg   <= '0;
         sticky  <= 1'b0;
         run_bit <= 1'b0;
         sign_r  <= 1'b0;
         cnt     <= '0;
         sp_inf  <= 1'b0;
         sp_zero <= 1'b0;
         sp_max  <= 1'b0;
         sp_min  <= 1'b0;
         out     <= '0;
         valid   <= 1'b0;
         inf     <= 1'b0;
         zero    <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  t_reg   <= {tail, {(N-1){1'b0}}};
                  sticky  <= 1'b0;
                  run_bit <= ~k_neg;
                  sign_r  <= sign;
                  cnt     <= in_special ? '0 : run_in;
                  sp_inf  <= inf_in;
                  sp_zero <= zero_in & ~inf_in;
                  sp_max  <= ~inf_in & ~zero_in & k_over;
                  sp_min  <= ~inf_in & ~zero_in & k_under;
               end
            end
            SHIFT: begin
               t_reg  <= {run_bit, t_reg[2*N-1:1]};
               sticky <= sticky | t_reg[0];
               cnt    <= cnt - ONE_RS;
            end
            ROUND: begin
               out   <= res;
               inf   <= sp_inf;
               zero  <= sp_zero;
               valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_posit_pack_seq.sv
// Testbench for posit_pack_seq.
// u_dut8 runs with WORD_SIZE=8, RS=3, ES=0; u_dut32 uses the default parameters.
// Results are checked against a bit-string reference model and against
// directed constants.
module tb_posit_pack_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst8, start8, sign8, zin8, iin8;
   logic [3:0] scale8;
   logic [7:0] frac8;
   logic       busy8, valid8, inf8, zero8;
   logic [7:0] out8;

   logic        rst32, start32, sign32, zin32, iin32;
   logic [7:0]  scale32;
   logic [29:0] frac32;
   logic        busy32, valid32, inf32, zero32;
   logic [31:0] out32;

   posit_pack_seq #(.WORD_SIZE(8), .RS(3), .ES(0)) u_dut8 (
      .clk(clk), .rst(rst8), .start(start8), .sign(sign8), .scale(scale8),
      .frac(frac8), .zero_in(zin8), .inf_in(iin8), .busy(busy8), .out(out8),
      .valid(valid8), .inf(inf8), .zero(zero8)
   );

   posit_pack_seq u_dut32 (
      .clk(clk), .rst(rst32), .start(start32), .sign(sign32), .scale(scale32),
      .frac(frac32), .zero_in(zin32), .inf_in(iin32), .busy(busy32), .out(out32),
      .valid(valid32), .inf(inf32), .zero(zero32)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: lay out regime, exponent and fraction as an unbounded bit
   // string, cut it after N-1 bits and round on what falls off.
   function automatic logic [31:0] ref_posit(input int n, input int es, input bit sgn,
                                             input int scl, input logic [31:0] frc,
                                             input bit zin, input bit iin);
      bit          q[$];
      int          k, e;
      logic [31:0] body, mag, mask, all_ones;
      bit          g, st;
      mask     = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
      all_ones = (32'd1 << (n - 1)) - 32'd1;
      if (iin) return 32'd1 << (n - 1);
      if (zin) return 32'd0;
      k = scl >>> es;
      e = scl & ((1 << es) - 1);
      if (k >= n - 2) begin
         mag = all_ones;
      end else if (k <= -(n - 1)) begin
         mag = 32'd1;
      end else begin
         if (k >= 0) begin
            repeat (k + 1) q.push_back(1'b1);
            q.push_back(1'b0);
         end else begin
            repeat (-k) q.push_back(1'b0);
            q.push_back(1'b1);
         end
         for (int i = es - 1; i >= 0; i--) q.push_back(e[i]);
         for (int i = n - es - 1; i >= 0; i--) q.push_back(frc[i]);
         body = 32'd0;
         for (int i = 0; i < n - 1; i++) body = {body[30:0], q[i]};
         g  = q[n - 1];
         st = 1'b0;
         for (int i = n; i < q.size(); i++) st = st | q[i];
         if (g && (st || body[0]) && body != all_ones) body = body + 32'd1;
         if (body == 32'd0) body = 32'd1;
         mag = body;
      end
      return sgn ? ((~mag + 32'd1) & mask) : mag;
   endfunction

   // edges from capture (edge 0) until valid is seen after an edge
   function automatic int ref_lat(input int n, input int es, input int scl,
                                  input bit zin, input bit iin);
      int k;
      k = scl >>> es;
      if (iin || zin || k >= n - 2 || k <= -(n - 1)) return 1;
      return ((k >= 0) ? k + 1 : -k) + 1;
   endfunction

   function automatic logic get_valid(input bit w);
      return w ? valid32 : valid8;
   endfunction

   function automatic logic get_busy(input bit w);
      return w ? busy32 : busy8;
   endfunction

   function automatic logic [31:0] get_out(input bit w);
      return w ? out32 : {24'd0, out8};
   endfunction

   task automatic drive(input bit w, input bit sg, input int scl, input logic [31:0] fr,
                        input bit zi, input bit ii);
      if (w) begin
         sign32 = sg; scale32 = 8'(scl); frac32 = fr[29:0]; zin32 = zi; iin32 = ii;
      end else begin
         sign8 = sg; scale8 = 4'(scl); frac8 = fr[7:0]; zin8 = zi; iin8 = ii;
      end
   endtask

   task automatic set_start(input bit w, input logic v);
      if (w) start32 = v;
      else start8 = v;
   endtask

   task automatic do_req(input string tag, input bit w, input bit sg, input int scl,
                         input logic [31:0] fr, input bit zi, input bit ii,
                         input logic [31:0] exp_out, input bit exp_inf,
                         input bit exp_zero, input int exp_lat);
      int          edges;
      logic        f_inf, f_zero;
      @(negedge clk);
      drive(w, sg, scl, fr, zi, ii);
      set_start(w, 1'b1);
      @(posedge clk);
      #1;
      set_start(w, 1'b0);
      check_val({tag, "_busy"}, 32'(get_busy(w)), 32'd1);
      edges = -1;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (get_valid(w)) begin
            edges = i;
            break;
         end
      end
      f_inf  = w ? inf32 : inf8;
      f_zero = w ? zero32 : zero8;
      check_val({tag, "_lat"}, 32'(edges), 32'(exp_lat));
      check_val({tag, "_out"}, get_out(w), exp_out);
      check_val({tag, "_inf"}, 32'(f_inf), 32'(exp_inf));
      check_val({tag, "_zero"}, 32'(f_zero), 32'(exp_zero));
      check_val({tag, "_busy_done"}, 32'(get_busy(w)), 32'd0);
      @(posedge clk);
      #1;
      check_val({tag, "_pulse"}, 32'(get_valid(w)), 32'd0);
   endtask

   task automatic rand_req(input bit w, input int idx);
      bit          sg, zi, ii;
      int          scl, n, es;
      logic [31:0] fr;
      n  = w ? 32 : 8;
      es = w ? 2 : 0;
      sg = 1'($urandom_range(0, 1));
      zi = ($urandom_range(0, 9) == 0);
      ii = ($urandom_range(0, 11) == 0);
      if (w) begin
         scl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) - 128
                                           : int'($urandom_range(0, 200)) - 100;
         fr  = {2'b00, 30'($urandom())};
      end else begin
         scl = int'($urandom_range(0, 15)) - 8;
         fr  = {24'd0, 8'($urandom())};
      end
      do_req($sformatf("rand%0d_%0d", n, idx), w, sg, scl, fr, zi, ii,
             ref_posit(n, es, sg, scl, fr, zi, ii), ii, zi & ~ii,
             ref_lat(n, es, scl, zi, ii));
   endtask

   initial begin
      int          npulse, at_edge, nv;
      logic [31:0] got;
      rst8 = 1'b1; rst32 = 1'b1;
      start8 = 1'b0; start32 = 1'b0;
      drive(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 0, 32'd0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst8 = 1'b0; rst32 = 1'b0;
      @(posedge clk);
      #1;
      check_val("rst_out8", {24'd0, out8}, 32'd0);
      check_val("rst_valid8", 32'(valid8), 32'd0);
      check_val("rst_busy8", 32'(busy8), 32'd0);
      check_val("rst_inf8", 32'(inf8), 32'd0);
      check_val("rst_zero8", 32'(zero8), 32'd0);
      check_val("rst_out32", out32, 32'd0);

      // directed cases, WORD_SIZE=8 ES=0
      do_req("unit_pos",   0, 0,  0, 32'h00, 0, 0, 32'h40, 0, 0, 2);
      do_req("unit_neg",   0, 1,  0, 32'h00, 0, 0, 32'hC0, 0, 0, 2);
      do_req("frac80",     0, 0,  0, 32'h80, 0, 0, 32'h50, 0, 0, 2);
      do_req("km1",        0, 0, -1, 32'h00, 0, 0, 32'h20, 0, 0, 2);
      do_req("km6",        0, 0, -6, 32'h00, 0, 0, 32'h01, 0, 0, 7);
      do_req("tie_even",   0, 0,  0, 32'h04, 0, 0, 32'h40, 0, 0, 2);
      do_req("tie_odd",    0, 0,  0, 32'h0C, 0, 0, 32'h42, 0, 0, 2);
      do_req("sticky",     0, 0,  0, 32'h06, 0, 0, 32'h41, 0, 0, 2);
      do_req("maxpos",     0, 0,  7, 32'h00, 0, 0, 32'h7F, 0, 0, 1);
      do_req("minpos",     0, 0, -7, 32'h00, 0, 0, 32'h01, 0, 0, 1);
      do_req("minpos_neg", 0, 1, -7, 32'h00, 0, 0, 32'hFF, 0, 0, 1);
      do_req("no_wrap",    0, 0,  5, 32'hFF, 0, 0, 32'h7F, 0, 0, 7);
      do_req("nar",        0, 1,  0, 32'h00, 1, 1, 32'h80, 1, 0, 1);
      do_req("zero",       0, 1,  0, 32'h00, 1, 0, 32'h00, 0, 1, 1);

      // start pulsed while busy must be ignored
      @(negedge clk);
      drive(1'b0, 1'b0, -6, 32'h00, 1'b0, 1'b0);
      start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      npulse = 0; at_edge = -1; got = 32'd0;
      for (int i = 1; i <= 20; i++) begin
         if (i == 2 || i == 4) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 0, 32'h80, 1'b0, 1'b0);
            start8 = 1'b1;
            @(posedge clk);
            #1;
            start8 = 1'b0;
         end else begin
            @(posedge clk);
            #1;
         end
         if (valid8) begin
            npulse++;
            if (at_edge < 0) begin
               at_edge = i;
               got = {24'd0, out8};
            end
         end
      end
      check_val("busy_ign_pulses", 32'(npulse), 32'd1);
      check_val("busy_ign_lat", 32'(at_edge), 32'd7);
      check_val("busy_ign_out", got, 32'h01);

      // start held high: one result every run+2 = 3 cycles
      @(negedge clk);
      drive(1'b0, 1'b0, 0, 32'h80, 1'b0, 1'b0);
      start8 = 1'b1;
      npulse = 0;
      for (int i = 0; i <= 11; i++) begin
         @(posedge clk);
         #1;
         if (valid8) begin
            npulse++;
            check_val($sformatf("held_edge_%0d", i), 32'(i % 3), 32'd2);
            check_val($sformatf("held_out_%0d", i), {24'd0, out8}, 32'h50);
         end
      end
      @(negedge clk);
      start8 = 1'b0;
      check_val("held_count", 32'(npulse), 32'd4);
      repeat (4) @(posedge clk);

      for (int i = 0; i < 40; i++) rand_req(1'b0, i);
      for (int i = 0; i < 25; i++) rand_req(1'b1, i);

      // make sure out32 holds something nonzero before the abort
      do_req("pre_abort", 1, 0, 60, 32'h0ABC_DEF1, 0, 0,
             ref_posit(32, 2, 0, 60, 32'h0ABC_DEF1, 0, 0), 0, 0, 17);

      // reset in the middle of SHIFT aborts the request
      @(negedge clk);
      drive(1'b1, 1'b1, 60, 32'h1234_5678, 1'b0, 1'b0);
      start32 = 1'b1;
      @(posedge clk);
      #1;
      start32 = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst32 = 1'b1;
      #1;
      check_val("abort_busy", 32'(busy32), 32'd0);
      check_val("abort_out", out32, 32'd0);
      check_val("abort_valid", 32'(valid32), 32'd0);
      @(negedge clk);
      rst32 = 1'b0;
      nv = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1;
         if (valid32) nv++;
      end
      check_val("abort_no_valid", 32'(nv), 32'd0);
      check_val("abort_out_held", out32, 32'd0);
      do_req("post_abort", 1, 1, 60, 32'h2345_6789, 0, 0,
             ref_posit(32, 2, 1, 60, 32'h2345_6789, 0, 0), 0, 0, 17);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
